// File: rtl/algo_rdport_sched.sv
`default_nettype none
// ============================================================================
// Module   : algo_rdport_sched
// Purpose  : Shares NUMRDPT memory read ports among NUMCLNT client read
//            requesters in round-robin order, tracks issued reads through a
//            tag pipeline and routes returned data/ECC flags to the client.
// Revision : 1.0 - initial release
// ============================================================================
module algo_rdport_sched #(
  parameter int WIDTH    = 32,
  parameter int BITADDR  = 13,
  parameter int NUMCLNT  = 8,
  parameter int BITCLNT  = 3,
  parameter int NUMRDPT  = 6,
  parameter int RD_DELAY = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic [NUMCLNT-1:0]         cl_read,
  input  logic [NUMCLNT*BITADDR-1:0] cl_adr,
  output logic [NUMCLNT-1:0]         cl_gnt,
  output logic [NUMCLNT-1:0]         cl_vld,
  output logic [NUMCLNT*WIDTH-1:0]   cl_dout,
  output logic [NUMCLNT-1:0]         cl_serr,
  output logic [NUMCLNT-1:0]         cl_derr,
  output logic [NUMRDPT-1:0]         read,
  output logic [NUMRDPT*BITADDR-1:0] rd_adr,
  input  logic [NUMRDPT-1:0]         rd_vld,
  input  logic [NUMRDPT*WIDTH-1:0]   rd_dout,
  input  logic [NUMRDPT-1:0]         rd_serr,
  input  logic [NUMRDPT-1:0]         rd_derr,
  output logic                       seq_err
);

  localparam int FLUSHW = $clog2(RD_DELAY + 2);

  logic [BITCLNT-1:0] rr_ptr;
  logic [BITCLNT-1:0] rr_next;
  logic               any_gnt;
  int                 offs     [NUMCLNT];
  int                 rank     [NUMCLNT];
  int                 max_off;
  int                 nxt;
  logic [NUMRDPT-1:0] port_vld;
  logic [BITCLNT-1:0] port_cl  [NUMRDPT];
  logic [BITADDR-1:0] port_adr [NUMRDPT];
  logic [BITCLNT-1:0] iss_id   [NUMRDPT];
  logic [NUMRDPT-1:0] tv_pipe  [RD_DELAY];
  logic [BITCLNT-1:0] id_pipe  [RD_DELAY][NUMRDPT];
  logic [FLUSHW-1:0]  flush;

  // Round-robin grant: a client's rank is the number of requesters ahead of it
  // in scan order from rr_ptr; rank also selects its port, so ports fill with no holes.
  always_comb begin
    cl_gnt   = '0;
    port_vld = '0;
    any_gnt  = 1'b0;
    max_off  = 0;
    nxt      = 0;
    rr_next  = rr_ptr;
    for (int k = 0; k < NUMRDPT; k++) begin
      port_cl[k]  = '0;
      port_adr[k] = '0;
    end
    for (int c = 0; c < NUMCLNT; c++) begin
      offs[c] = (c >= int'(rr_ptr)) ? (c - int'(rr_ptr)) : (c + NUMCLNT - int'(rr_ptr));
    end
    for (int c = 0; c < NUMCLNT; c++) begin
      rank[c] = 0;
      for (int d = 0; d < NUMCLNT; d++) begin
        if (cl_read[d] && (offs[d] < offs[c])) rank[c] = rank[c] + 1;
      end
    end
    for (int c = 0; c < NUMCLNT; c++) begin
      if (ready && !rst && cl_read[c] && (rank[c] < NUMRDPT)) begin
        cl_gnt[c] = 1'b1;
        any_gnt   = 1'b1;
        if (offs[c] > max_off) max_off = offs[c];
        for (int k = 0; k < NUMRDPT; k++) begin
          if (rank[c] == k) begin
            port_vld[k] = 1'b1;
            port_cl[k]  = BITCLNT'(c);
            port_adr[k] = cl_adr[c*BITADDR +: BITADDR];
          end
        end
      end
    end
    // pointer moves just past the last granted client in scan order
    nxt = int'(rr_ptr) + max_off + 1;
    if (nxt >= NUMCLNT) nxt = nxt - NUMCLNT;
    rr_next = BITCLNT'(nxt);
  end

  // Pointer register and registered issue of granted addresses onto the ports
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      read   <= '0;
      rd_adr <= '0;
      for (int k = 0; k < NUMRDPT; k++) iss_id[k] <= '0;
    end else begin
      if (any_gnt) rr_ptr <= rr_next;
      read <= port_vld;
      for (int k = 0; k < NUMRDPT; k++) begin
        rd_adr[k*BITADDR +: BITADDR] <= port_adr[k];
        iss_id[k]                    <= port_cl[k];
      end
    end
  end

  // Tag pipeline fed by the registered read, so its last stage lines up with rd_vld
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_DELAY; s++) begin
        tv_pipe[s] <= '0;
        for (int k = 0; k < NUMRDPT; k++) id_pipe[s][k] <= '0;
      end
    end else begin
      tv_pipe[0] <= read;
      for (int k = 0; k < NUMRDPT; k++) id_pipe[0][k] <= iss_id[k];
      for (int s = 1; s < RD_DELAY; s++) begin
        tv_pipe[s] <= tv_pipe[s-1];
        for (int k = 0; k < NUMRDPT; k++) id_pipe[s][k] <= id_pipe[s-1][k];
      end
    end
  end

  // Route tagged returns back to the originating client; untouched slices hold
  always_ff @(posedge clk) begin
    if (rst) begin
      cl_vld  <= '0;
      cl_dout <= '0;
      cl_serr <= '0;
      cl_derr <= '0;
    end else begin
      cl_vld <= '0;
      for (int p = 0; p < NUMRDPT; p++) begin
        for (int c = 0; c < NUMCLNT; c++) begin
          if (rd_vld[p] && tv_pipe[RD_DELAY-1][p] && (id_pipe[RD_DELAY-1][p] == BITCLNT'(c))) begin
            cl_vld[c]                <= 1'b1;
            cl_dout[c*WIDTH +: WIDTH] <= rd_dout[p*WIDTH +: WIDTH];
            cl_serr[c]               <= rd_serr[p];
            cl_derr[c]               <= rd_derr[p];
          end
        end
      end
    end
  end

  // Sticky sequence check, masked while reads from before reset may still return
  always_ff @(posedge clk) begin
    if (rst) begin
      flush   <= FLUSHW'(RD_DELAY + 1);
      seq_err <= 1'b0;
    end else if (flush != '0) begin
      flush <= flush - FLUSHW'(1);
    end else if (rd_vld != tv_pipe[RD_DELAY-1]) begin
      seq_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire
